axi_rd_burst_init: RTL

AXI4 read-channel initiator for the tfacc_u8 data path. It takes a read command (start byte address and length in 128-bit beats) and splits it into AR bursts that never exceed MAX_BURST beats or cross a 4 KB boundary. It collects the R beats into an internal FIFO and presents them on a valid/ready stream to the compute core. It is the initiating end of the same AR/R interface that the simulation memory responder answers.

---
 rtl/tfacc_axi_pkg.sv | 23 ++
 rtl/rd_fifo.sv | 68 ++++++
 rtl/axi_rd_burst_init.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/tfacc_axi_pkg.sv
// Shared types and helpers for the tfacc_u8 AXI read initiator.
// Beat/page geometry and the initiator state encoding live here.
package tfacc_axi_pkg;

    localparam int ADDR_W     = 40;
    localparam int DATA_W     = 128;
    localparam int BEAT_BYTES = 16;
    localparam int PAGE_BYTES = 4096;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_ADDR,
        S_DATA,
        S_FIN
    } rdi_state_t;

    // Beats left before the next 4 KB page; takes the beat index addr[11:4].
    function automatic logic [8:0] beats_to_page(input logic [7:0] addr);
        return 9'(PAGE_BYTES / BEAT_BYTES) - {1'b0, addr};
    endfunction

endpackage

// File: rtl/rd_fifo.sv
// Synchronous beat FIFO with a registered output stage.
// count covers both the storage array and the output register.
module rd_fifo #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid,
    input  logic              dready,
    output logic [CW-1:0]     count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [CW-1:0]     mcount;
    logic              load;
    logic              mem_rd;
    logic              mem_wr;

    assign load   = !dvalid || dready;
    assign mem_rd = load && (mcount != '0);
    // An empty array lets a pushed beat go straight into the output register.
    assign mem_wr = push && !(load && (mcount == '0));
    assign count  = mcount + CW'(dvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp     <= '0;
            rp     <= '0;
            mcount <= '0;
            dout   <= '0;
            dvalid <= 1'b0;
        end else begin
            if (mem_wr) begin
                wp <= wp + AW'(1);
            end
            if (mem_rd) begin
                rp <= rp + AW'(1);
            end
            mcount <= mcount + CW'(mem_wr) - CW'(mem_rd);
            if (load) begin
                if (mem_rd) begin
                    dout   <= mem[rp];
                    dvalid <= 1'b1;
                end else if (push) begin
                    dout   <= wdata;
                    dvalid <= 1'b1;
                end else begin
                    dvalid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wp] <= wdata;
        end
    end

endmodule

// File: rtl/axi_rd_burst_init.sv
// AXI4 read initiator: splits a beat command into page-safe AR bursts
// and streams the returned R beats out through rd_fifo.
module axi_rd_burst_init #(
    parameter int ADDR_W     = 40,
    parameter int DATA_W     = 128,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic              aclk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [23:0]       n_beats,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic              arvalid,
    input  logic              arready,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              rvalid,
    input  logic              rlast,
    output logic              rready,
    output logic [DATA_W-1:0] dout,
    output logic              dvalid,
    input  logic              dready
);

    import tfacc_axi_pkg::*;

    localparam int         CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [8:0] MB = 9'(MAX_BURST);

    rdi_state_t        state;
    rdi_state_t        state_n;
    logic [ADDR_W-1:0] addr;
    logic [23:0]       rem;
    logic [8:0]        len;
    logic [8:0]        len_c;
    logic [8:0]        cnt;
    logic [8:0]        cnt_inc;
    logic [CW-1:0]     fcount;
    logic [31:0]       space;
    logic              fits;
    logic              beat;
    logic              at_len;
    logic              burst_end;
    logic              unused_lsb;

    assign unused_lsb = ^src_addr[3:0];

    always_comb begin
        len_c = beats_to_page(addr[11:4]);
        if (MB < len_c) begin
            len_c = MB;
        end
        if (rem < 24'(len_c)) begin
            len_c = rem[8:0];
        end
    end

    // Space is reserved before the AR goes out, so R never back-pressures.
    assign space     = 32'(FIFO_DEPTH) - 32'(fcount);
    assign fits      = space >= 32'(len_c);
    assign cnt_inc   = cnt + 9'd1;
    assign beat      = (state == S_DATA) && rvalid;
    assign at_len    = cnt_inc == len;
    assign burst_end = beat && (at_len || rlast);

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_CALC;
                end
            end
            S_CALC: begin
                if (rem == '0) begin
                    state_n = S_FIN;
                end else if (fits) begin
                    state_n = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arready) begin
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (burst_end) begin
                    state_n = S_CALC;
                end
            end
            S_FIN: begin
                if (fcount == '0) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        arvalid = 1'b0;
        araddr  = '0;
        arlen   = '0;
        rready  = 1'b0;
        done    = 1'b0;
        busy    = state != S_IDLE;
        unique case (state)
            S_ADDR: begin
                arvalid = 1'b1;
                araddr  = addr;
                arlen   = 8'(len - 9'd1);
            end
            S_DATA: rready = 1'b1;
            S_FIN:  done   = fcount == '0;
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            addr <= '0;
            rem  <= '0;
            len  <= '0;
            cnt  <= '0;
            err  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        addr <= {src_addr[ADDR_W-1:4], 4'h0};
                        rem  <= n_beats;
                        cnt  <= '0;
                        err  <= 1'b0;
                    end
                end
                S_CALC: len <= len_c;
                S_DATA: begin
                    if (beat) begin
                        // rlast must coincide exactly with the len-th beat.
                        if (rlast != at_len) begin
                            err <= 1'b1;
                        end
                        if (burst_end) begin
                            cnt  <= '0;
                            rem  <= rem - 24'(cnt_inc);
                            addr <= addr + (ADDR_W'(cnt_inc) << 4);
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk    (aclk),
        .rst_n  (arst_n),
        .push   (beat),
        .wdata  (rd_data),
        .dout   (dout),
        .dvalid (dvalid),
        .dready (dready),
        .count  (fcount)
    );

endmodule
